ram8: RTL and testbench



---
 rtl/hack_defs.sv | 13 +
 rtl/ram8_register16.sv | 33 +++
 rtl/ram8.sv | 62 ++++++
 tb/tb_ram8.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hack_defs.sv
// Shared word-level constants for the register-memory family (RAM8, RAM64, RAM512...).
package hack_defs;

   localparam int unsigned WORD_W      = 16;
   localparam int unsigned RAM8_ADDR_W = 3;
   localparam int unsigned RAM8_DEPTH  = 1 << RAM8_ADDR_W;

   localparam logic [WORD_W-1:0] WORD_ZERO = 16'h0000;

   typedef logic [WORD_W-1:0]      word_t;
   typedef logic [RAM8_ADDR_W-1:0] ram8_addr_t;

endpackage : hack_defs

// File: rtl/ram8_register16.sv
// One 16-bit storage word: synchronous active-high clear, load on edge, hold otherwise.
module register16
   import hack_defs::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] in,
   input  logic              load,
   output logic [WORD_W-1:0] out
);

   word_t word_q;
   word_t word_d;

   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = in;
      end
   end

   // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         word_q <= WORD_ZERO;
      end else begin
         word_q <= word_d;
      end
   end

   assign out = word_q;

endmodule : register16

// File: rtl/ram8.sv
// Eight-word register memory: load is demultiplexed on address, read is a combinational mux.
module ram8
   import hack_defs::*;
#(
   parameter int unsigned WIDTH = WORD_W,
   parameter int unsigned DEPTH = RAM8_DEPTH
)
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in,
   input  logic                   load,
   input  logic [RAM8_ADDR_W-1:0] address,
   output logic [WIDTH-1:0]       out
);

   logic [DEPTH-1:0] load_en;
   word_t            words [DEPTH];

   // NOTE: default assigned first so the decode can never infer a latch; an unknown
   // address matches no case item and leaves every enable at 0.
   always_comb begin
      load_en = '0;
      case (address)
         3'd0: load_en[0] = load;
         3'd1: load_en[1] = load;
         3'd2: load_en[2] = load;
         3'd3: load_en[3] = load;
         3'd4: load_en[4] = load;
         3'd5: load_en[5] = load;
         3'd6: load_en[6] = load;
         3'd7: load_en[7] = load;
         default: load_en = '0;
      endcase
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      register16 u_word (
         .clock (clock),
         .reset (reset),
         .in    (in),
         .load  (load_en[k]),
         .out   (words[k])
      );
   end

   always_comb begin
      out = WORD_ZERO;
      case (address)
         3'd0: out = words[0];
         3'd1: out = words[1];
         3'd2: out = words[2];
         3'd3: out = words[3];
         3'd4: out = words[4];
         3'd5: out = words[5];
         3'd6: out = words[6];
         3'd7: out = words[7];
         default: out = WORD_ZERO;
      endcase
   end

endmodule : ram8

// File: tb/tb_ram8.sv
// Directed bench for ram8 with hand-computed expected words.
module tb_ram8;

   logic        clock;
   logic        reset;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic [15:0] out;

   int unsigned n_vectors;
   int unsigned n_miscompares;

   ram8 dut (
      .clock   (clock),
      .reset   (reset),
      .in      (in),
      .load    (load),
      .address (address),
      .out     (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
      address = a;
      #1;
      check($sformatf("%s[%0d]", tag, a), out, exp);
   endtask

   task automatic fill_all();
      for (int k = 0; k < 8; k++) begin
         write_word(3'(k), 16'h1111 * 16'(k + 1));
      end
   endtask

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      reset   = 1'b0;
      load    = 1'b0;
      in      = 16'h0000;
      address = 3'd0;
      #2;

      // Reset wins over a simultaneous write to word 5.
      reset   = 1'b1;
      load    = 1'b1;
      address = 3'd5;
      in      = 16'hBEEF;
      step();
      reset = 1'b0;
      load  = 1'b0;
      for (int k = 0; k < 8; k++) read_check("reset_clear", 3'(k), 16'h0000);

      fill_all();
      for (int k = 0; k < 8; k++) read_check("fill", 3'(k), 16'h1111 * 16'(k + 1));

      // Read-during-write on word 3.
      write_word(3'd3, 16'h00AA);
      address = 3'd3;
      in      = 16'h5555;
      load    = 1'b1;
      #1;
      check("rdw_before", out, 16'h00AA);
      step();
      check("rdw_after", out, 16'h5555);
      load = 1'b0;
      read_check("rdw_neighbour", 3'd2, 16'h3333);
      read_check("rdw_neighbour", 3'd4, 16'h5555);

      // No write without load.
      address = 3'd6;
      in      = 16'hFFFF;
      load    = 1'b0;
      repeat (3) step();
      check("no_load", out, 16'h7777);

      // Last write wins.
      write_word(3'd1, 16'h0001);
      write_word(3'd1, 16'h0002);
      read_check("last_wins", 3'd1, 16'h0002);
      read_check("last_wins_other", 3'd0, 16'h1111);

      // Reset mid-sequence discards everything including the pending write.
      fill_all();
      reset   = 1'b1;
      load    = 1'b1;
      address = 3'd7;
      in      = 16'h1234;
      step();
      reset = 1'b0;
      load  = 1'b0;
      for (int k = 0; k < 8; k++) read_check("mid_reset", 3'(k), 16'h0000);
      write_word(3'd7, 16'h1234);
      read_check("post_reset_write", 3'd7, 16'h1234);
      read_check("post_reset_other", 3'd6, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule : tb_ram8
